// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: opcode and TX state encodings shared by the SPI RAM controller.
package spi_ram_pkg;

    localparam int OPCODE_W = 2;

    typedef enum logic [OPCODE_W-1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } tx_state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: storage array with one synchronous write port and one registered read port.
module spi_ram_mem
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 re,
    input  logic                 rz,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];
    logic [DATA_SIZE-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr[AW-1:0]] <= wdata;
    end

    // rz forces a zero word for reads outside the populated range
    always_ff @(posedge clk) begin
        rdata_q <= rst ? '0 : re ? (rz ? '0 : mem_q[raddr[AW-1:0]]) : rdata_q;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: SPI command decode, address pointers, TX handshake FSM and range errors.
// Define SPI_RAM_AUTOINC_EN to post-increment pointers after in-range data accesses.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [DATA_SIZE+1:0] din,
    input  logic                 tx_ready,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 tx_valid,
    output logic [ADDR_SIZE-1:0] write_address,
    output logic [ADDR_SIZE-1:0] read_address,
    output logic                 cmd_err
);

`ifdef SPI_RAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [ADDR_SIZE:0]   DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST  = ADDR_SIZE'(MEM_DEPTH - 1);

    function automatic logic [ADDR_SIZE-1:0] wrap_inc(input logic [ADDR_SIZE-1:0] a);
        return (a == LAST) ? '0 : a + 1'b1;
    endfunction

    opcode_e              op;
    logic [DATA_SIZE-1:0] payload;
    logic                 wr_oob, rd_oob, wr_cmd, rd_cmd, rd_acc, rd_drop, we;
    logic [ADDR_SIZE-1:0] wa_q, wa_d, ra_q, ra_d;
    tx_state_e            state_q;
    logic                 tx_valid_q, cmd_err_q;

    assign op      = opcode_e'(din[DATA_SIZE+1:DATA_SIZE]);
    assign payload = din[DATA_SIZE-1:0];

    always_comb begin
        wr_oob  = {1'b0, wa_q} >= DEPTH;
        rd_oob  = {1'b0, ra_q} >= DEPTH;
        wr_cmd  = rx_valid && op == WR_DATA;
        rd_cmd  = rx_valid && op == RD_DATA;
        rd_acc  = rd_cmd && (state_q == IDLE || tx_ready);
        rd_drop = rd_cmd && !rd_acc;
        we      = wr_cmd && !wr_oob;
        wa_d    = (rx_valid && op == WR_ADDR) ? payload[ADDR_SIZE-1:0] :
                  (AUTOINC && we) ? wrap_inc(wa_q) : wa_q;
        ra_d    = (rx_valid && op == RD_ADDR) ? payload[ADDR_SIZE-1:0] :
                  (AUTOINC && rd_acc && !rd_oob) ? wrap_inc(ra_q) : ra_q;
    end

    always_ff @(posedge clk) begin
        wa_q <= rst ? '0 : wa_d;
        ra_q <= rst ? '0 : ra_d;
    end

    // A read accepted while the previous word is being taken keeps the FSM in HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            cmd_err_q <= (wr_cmd && wr_oob) || rd_drop || (rd_acc && rd_oob);
            if (rd_acc) begin
                state_q    <= HOLD;
                tx_valid_q <= 1'b1;
            end else if (state_q == HOLD && tx_ready) begin
                state_q    <= IDLE;
                tx_valid_q <= 1'b0;
            end
        end
    end

    spi_ram_mem #(
        .ADDR_SIZE(ADDR_SIZE),
        .DATA_SIZE(DATA_SIZE),
        .MEM_DEPTH(MEM_DEPTH)
    ) u_mem (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .waddr(wa_q),
        .wdata(payload),
        .re   (rd_acc),
        .rz   (rd_oob),
        .raddr(ra_q),
        .rdata(dout)
    );

    assign tx_valid      = tx_valid_q;
    assign cmd_err       = cmd_err_q;
    assign write_address = wa_q;
    assign read_address  = ra_q;

endmodule
